arm_banked_regfile: RTL
=======================

Name: arm_banked_regfile

Overview:
- Parametrised successor to the core's flat r0–r15 register file.
- Adds ARM-style mode banking of SP/LR with per-mode SPSR, one-cycle exception entry/return sequencing, posedge-registered reads with write bypass, and a reset vector.
- Sits between decode (read selects) and execute/writeback (write port, PC, flags).
- Single clock domain.

Parameters:
- DATA_W, 32, register/PC width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- FLAGS_W, 4, width of the NZCV flags field.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  general write strobe.
- wr_sel  in  4  general write register index.
- wr_data  in  DATA_W  general write data.
- rd_sel0, rd_sel1  in  4 each  read indices.
- rd_data0, rd_data1  out  DATA_W each  registered read data.
- pc_wr_en  in  1  PC write strobe.
- pc_in  in  DATA_W  next PC.
- pc_out  out  DATA_W  current PC (r15), direct from the PC register.
- flags_wr_en  in  1  flags write strobe.
- flags_in  in  FLAGS_W  new flags.
- flags_out  out  FLAGS_W  current flags (CPSR NZCV).
- exc_entry  in  1  one-cycle exception-entry request.
- exc_mode  in  2  target mode: 0=USR, 1=IRQ, 2=SVC, 3=FIQ.
- exc_ret_addr  in  DATA_W  value loaded into the banked LR on entry.
- exc_vector  in  DATA_W  value loaded into the PC on entry.
- exc_return  in  1  one-cycle exception-return request.
- mode  out  2  current processor mode.

Behaviour:
- Reset (async, reset_n=0):
  - r0–r12 and all banked r13/r14 = 0; all SPSRs = 0.
  - PC = RESET_VECTOR; flags = 0; mode = SVC (2).
  - rd_data0 and rd_data1 = 0.
- Storage:
  - r0–r12 are shared across modes.
  - r13/r14 are banked for USR, IRQ and SVC.
  - SPSR exists for IRQ and SVC; each holds {prev_mode[1:0], flags}.
  - r15 is the PC register.
- Reads:
  - rd_dataN is registered at posedge: 1-cycle latency.
  - The value is the state before the edge, using the bank of the pre-edge mode.
  - Index 15 returns the pre-edge PC.
- Bypass:
  - Applies when a general write is accepted this cycle and wr_sel==rd_selN, with wr_sel≠15.
  - rd_dataN then returns wr_data.
  - No bypass for PC, flags or exception-driven updates.
- General write:
  - wr_en writes the current-mode bank.
  - wr_sel=15 writes the PC, unless pc_wr_en is also high; pc_wr_en wins.
- Priority per cycle, highest first:
  1. Valid exc_entry.
  2. Valid exc_return.
  3. Normal writes (wr_en, pc_wr_en, flags_wr_en).
- Exception entry:
  - Valid when exc_entry=1 and exc_mode is IRQ or SVC (or FIQ when enabled).
  - In one cycle:
    - SPSR[exc_mode] <= {mode, flags}.
    - LR[exc_mode] <= exc_ret_addr.
    - PC <= exc_vector.
    - mode <= exc_mode.
  - All normal writes that cycle are dropped; flags are unchanged.
  - Re-entering the current mode overwrites its SPSR/LR (nesting is software's responsibility).
  - Invalid exc_mode (USR, or FIQ when disabled): request ignored; normal writes proceed.
- Exception return:
  - Valid when exc_return=1, exc_entry=0 and mode≠USR.
  - In one cycle:
    - PC <= LR[mode].
    - {mode, flags} <= SPSR[mode].
  - Normal writes are dropped.
  - exc_return in USR is ignored; normal writes proceed.
- Simultaneous entry and return: entry wins; return is discarded.
- Reset asserted mid-operation: immediate return to reset values, including mode.
- pc_out, flags_out and mode are driven directly from their registers: the new value is visible the cycle after the edge.

Optional Feature:
REGFILE_FIQ_BANK_EN:
- Defined:
  - Mode 3 (FIQ) is legal.
  - FIQ has private r8–r14 and SPSR_fiq, all reset to 0.
  - In FIQ mode, reads, writes and bypass on indices 8–14 use the FIQ bank.
- Undefined:
  - exc_mode=3 entry is ignored; mode never becomes 3; no FIQ storage is built.
  - A corrupted SPSR restore yielding mode 3 is forced to USR.

Test Plan:
- Reset: reset_n=0 → PC=RESET_VECTOR, mode=2, flags=0, rd_data0/1=0. Release reset, then read r13 → 0.
- Write r3=32'hDEAD_BEEF with rd_sel0=3 in the same cycle → rd_data0=32'hDEAD_BEEF next cycle (bypass). rd_sel1=15 → pre-edge PC.
- Setup: in SVC, write r13=32'h100; then return to USR via SPSR_svc (mode=0) and write r13=32'h200. Action: exc_entry, exc_mode=1, exc_ret_addr=32'h44, exc_vector=32'h18, flags=4'b1010. Response: mode=1, PC=32'h18, SPSR_irq={0,1010}; read r14 → 32'h44, r13 → 0 (IRQ bank).
- From IRQ, set flags=4'b0001, then exc_return → PC=32'h44, mode=0, flags=4'b1010; read r13 → 32'h200.
- exc_entry and exc_return high together with wr_en (r1=5) → entry taken, r1 unchanged, return ignored. exc_return in USR with wr_en (r1=5) → r1=5, mode stays 0.
- With REGFILE_FIQ_BANK_EN: write r8=7 in USR; enter FIQ; write r8=9; read r8 → 9; exc_return; read r8 → 7. Without the macro: exc_mode=3 → mode and PC unchanged.

Source files
------------

// File: rtl/arm_banked_regfile.sv
// ARM-style register file: shared r0-r12, SP/LR/SPSR banked per mode, one-cycle exception
// entry/return, registered reads with write bypass. Define REGFILE_FIQ_BANK_EN for the FIQ bank.
module arm_banked_regfile #(
  parameter int unsigned       DATA_W       = 32,
  parameter logic [DATA_W-1:0] RESET_VECTOR = '0,
  parameter int unsigned       FLAGS_W      = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [3:0]         wr_sel,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [3:0]         rd_sel0,
  input  logic [3:0]         rd_sel1,
  output logic [DATA_W-1:0]  rd_data0,
  output logic [DATA_W-1:0]  rd_data1,
  input  logic               pc_wr_en,
  input  logic [DATA_W-1:0]  pc_in,
  output logic [DATA_W-1:0]  pc_out,
  input  logic               flags_wr_en,
  input  logic [FLAGS_W-1:0] flags_in,
  output logic [FLAGS_W-1:0] flags_out,
  input  logic               exc_entry,
  input  logic [1:0]         exc_mode,
  input  logic [DATA_W-1:0]  exc_ret_addr,
  input  logic [DATA_W-1:0]  exc_vector,
  input  logic               exc_return,
  output logic [1:0]         mode
);

  localparam logic [1:0] MODE_USR = 2'd0;
  localparam logic [1:0] MODE_IRQ = 2'd1;
  localparam logic [1:0] MODE_SVC = 2'd2;
  localparam logic [1:0] MODE_FIQ = 2'd3;
  localparam int unsigned SPSR_W = FLAGS_W + 2;

  logic [DATA_W-1:0]  gpr_q [13];
  logic [DATA_W-1:0]  sp_q  [3];  // indexed by USR/IRQ/SVC
  logic [DATA_W-1:0]  lr_q  [3];
  logic [SPSR_W-1:0]  spsr_irq_q, spsr_svc_q;
  logic [DATA_W-1:0]  pc_q;
  logic [FLAGS_W-1:0] flags_q;
  logic [1:0]         mode_q;
`ifdef REGFILE_FIQ_BANK_EN
  localparam bit FiqEn = 1'b1;
  logic [DATA_W-1:0]  fiq_q [7];  // private r8..r14
  logic [SPSR_W-1:0]  spsr_fiq_q;
`else
  localparam bit FiqEn = 1'b0;
`endif

  logic              entry_ok, ret_ok;
  logic [SPSR_W-1:0] spsr_cur;
  logic [1:0]        spsr_mode, ret_mode;
  logic [DATA_W-1:0] lr_cur, rd_next0, rd_next1;

  function automatic logic [DATA_W-1:0] read_reg(input logic [3:0] sel);
    logic [DATA_W-1:0] v;
    if (sel == 4'd15) v = pc_q;
`ifdef REGFILE_FIQ_BANK_EN
    else if (mode_q == MODE_FIQ && sel >= 4'd8) v = fiq_q[3'(sel - 4'd8)];
`endif
    else if (sel == 4'd13) v = sp_q[mode_q];
    else if (sel == 4'd14) v = lr_q[mode_q];
    else v = gpr_q[sel];
    return v;
  endfunction

  always_comb begin
    entry_ok = exc_entry &&
               (exc_mode == MODE_IRQ || exc_mode == MODE_SVC || (FiqEn && exc_mode == MODE_FIQ));
    ret_ok   = exc_return && !exc_entry && mode_q != MODE_USR;
    case (mode_q)
      MODE_IRQ: spsr_cur = spsr_irq_q;
      MODE_SVC: spsr_cur = spsr_svc_q;
`ifdef REGFILE_FIQ_BANK_EN
      MODE_FIQ: spsr_cur = spsr_fiq_q;
`endif
      default:  spsr_cur = '0;
    endcase
    spsr_mode = spsr_cur[SPSR_W-1 -: 2];
    // Without the FIQ bank a restored mode 3 is meaningless; fall back to USR.
    ret_mode  = (!FiqEn && spsr_mode == MODE_FIQ) ? MODE_USR : spsr_mode;
    lr_cur    = read_reg(4'd14);
    rd_next0  = read_reg(rd_sel0);
    rd_next1  = read_reg(rd_sel1);
    if (!entry_ok && !ret_ok && wr_en && wr_sel != 4'd15) begin
      if (wr_sel == rd_sel0) rd_next0 = wr_data;
      if (wr_sel == rd_sel1) rd_next1 = wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 13; i++) gpr_q[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        sp_q[i] <= '0;
        lr_q[i] <= '0;
      end
      spsr_irq_q <= '0;
      spsr_svc_q <= '0;
`ifdef REGFILE_FIQ_BANK_EN
      for (int i = 0; i < 7; i++) fiq_q[i] <= '0;
      spsr_fiq_q <= '0;
`endif
      pc_q    <= RESET_VECTOR;
      flags_q <= '0;
      mode_q  <= MODE_SVC;
    end else if (entry_ok) begin
      pc_q   <= exc_vector;
      mode_q <= exc_mode;
      case (exc_mode)
        MODE_IRQ: begin
          spsr_irq_q <= {mode_q, flags_q};
          lr_q[1]    <= exc_ret_addr;
        end
        MODE_SVC: begin
          spsr_svc_q <= {mode_q, flags_q};
          lr_q[2]    <= exc_ret_addr;
        end
`ifdef REGFILE_FIQ_BANK_EN
        MODE_FIQ: begin
          spsr_fiq_q <= {mode_q, flags_q};
          fiq_q[6]   <= exc_ret_addr;
        end
`endif
        default: ;
      endcase
    end else if (ret_ok) begin
      pc_q    <= lr_cur;
      mode_q  <= ret_mode;
      flags_q <= spsr_cur[FLAGS_W-1:0];
    end else begin
      if (wr_en && wr_sel != 4'd15) begin
`ifdef REGFILE_FIQ_BANK_EN
        if (mode_q == MODE_FIQ && wr_sel >= 4'd8) fiq_q[3'(wr_sel - 4'd8)] <= wr_data;
        else
`endif
        if (wr_sel == 4'd13) sp_q[mode_q] <= wr_data;
        else if (wr_sel == 4'd14) lr_q[mode_q] <= wr_data;
        else gpr_q[wr_sel] <= wr_data;
      end
      if (pc_wr_en) pc_q <= pc_in;
      else if (wr_en && wr_sel == 4'd15) pc_q <= wr_data;
      if (flags_wr_en) flags_q <= flags_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_data0 <= '0;
      rd_data1 <= '0;
    end else begin
      rd_data0 <= rd_next0;
      rd_data1 <= rd_next1;
    end
  end

  assign pc_out    = pc_q;
  assign flags_out = flags_q;
  assign mode      = mode_q;

endmodule
